// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared constants and helpers for the stopwatch core
package stopwatch_pkg;

    localparam logic [5:0] MAX_VAL = 6'd59;

    localparam logic [1:0] DIG_SEC_ONES = 2'd0;
    localparam logic [1:0] DIG_SEC_TENS = 2'd1;
    localparam logic [1:0] DIG_MIN_ONES = 2'd2;
    localparam logic [1:0] DIG_MIN_TENS = 2'd3;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [5:0] inc_wrap(input logic [5:0] v);
        return (v == MAX_VAL) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [3:0] tens_of(input logic [5:0] v);
        logic [5:0] t;
        t = v / 6'd10;
        return t[3:0];
    endfunction

    function automatic logic [3:0] ones_of(input logic [5:0] v);
        logic [5:0] o;
        o = v % 6'd10;
        return o[3:0];
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational digit to active-low 7-segment decoder
module seg7_decoder
    import stopwatch_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - mm:ss stopwatch with run/pause, adjust mode and multiplexed display
module stopwatch_core
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       one_hz,
    input  logic       two_hz,
    input  logic       fast_clk,
    input  logic       blink_clk,
    input  logic       pause,
    input  logic       adj,
    input  logic       sel,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [3:0] an,
    output logic [6:0] seg
);

    logic       one_prev_q, two_prev_q, fast_prev_q;
    logic       one_tick, two_tick, fast_tick;
    logic       paused_q, paused_d;
    logic [5:0] minutes_q, minutes_d;
    logic [5:0] seconds_q, seconds_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic [3:0] digit;
    logic [6:0] seg_dec;
    logic       blank;

    assign one_tick  = one_hz   & ~one_prev_q;
    assign two_tick  = two_hz   & ~two_prev_q;
    assign fast_tick = fast_clk & ~fast_prev_q;

    always_comb begin
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        paused_d  = paused_q ^ pause;
        idx_d     = fast_tick ? idx_q + 2'd1 : idx_q;
        // Adjust mode owns the counters outright; one_hz is dropped, not deferred
        if (adj) begin
            if (two_tick) begin
                if (sel) seconds_d = inc_wrap(seconds_q);
                else     minutes_d = inc_wrap(minutes_q);
            end
        end else if (!paused_q && one_tick) begin
            seconds_d = inc_wrap(seconds_q);
            if (seconds_q == MAX_VAL) minutes_d = inc_wrap(minutes_q);
        end
    end

    always_comb begin
        case (idx_q)
            DIG_SEC_ONES: digit = ones_of(seconds_q);
            DIG_SEC_TENS: digit = tens_of(seconds_q);
            DIG_MIN_ONES: digit = ones_of(minutes_q);
            default:      digit = tens_of(minutes_q);
        endcase
    end

    seg7_decoder u_dec (
        .digit_i (digit),
        .seg_o   (seg_dec)
    );

    always_comb begin
        blank = 1'b0;
        if (adj && blink_clk) begin
            if (sel) blank = (idx_q == DIG_SEC_ONES) || (idx_q == DIG_SEC_TENS);
            else     blank = (idx_q == DIG_MIN_ONES) || (idx_q == DIG_MIN_TENS);
        end
        an_d  = ~(4'b0001 << idx_q);
        seg_d = blank ? SEG_BLANK : seg_dec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            one_prev_q  <= 1'b0;
            two_prev_q  <= 1'b0;
            fast_prev_q <= 1'b0;
            paused_q    <= 1'b0;
            minutes_q   <= 6'd0;
            seconds_q   <= 6'd0;
            idx_q       <= 2'd0;
            an_q        <= 4'b1111;
            seg_q       <= SEG_BLANK;
        end else begin
            one_prev_q  <= one_hz;
            two_prev_q  <= two_hz;
            fast_prev_q <= fast_clk;
            paused_q    <= paused_d;
            minutes_q   <= minutes_d;
            seconds_q   <= seconds_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign minutes = minutes_q;
    assign seconds = seconds_q;
    assign an      = an_q;
    assign seg     = seg_q;

endmodule
